vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Shares the single write port of the VGA adapter (160x120, 3-bit colour) between the snake draw/erase path and the food spawn path. It also owns an optional full-screen clear sweep used at reset and game-over. All requesters hand over one pixel per transfer on a valid/ready handshake. The block drives the adapter's x, y, colour and plot from registers, so plot is no longer tied high.

## Interface
Parameters:
- SCR_W, 160, screen width in pixels; x range 0..SCR_W-1
- SCR_H, 120, screen height in pixels; y range 0..SCR_H-1
- BG_COLOUR, 3'b000, colour written by the clear sweep

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- snake_valid  in  1  snake requester has a pixel
- snake_x  in  8  snake pixel x
- snake_y  in  7  snake pixel y
- snake_colour  in  3  snake pixel colour
- snake_ready  out  1  snake transfer accepted this cycle
- food_valid  in  1  food requester has a pixel
- food_x  in  8  food pixel x
- food_y  in  7  food pixel y
- food_colour  in  3  food pixel colour
- food_ready  out  1  food transfer accepted this cycle
- clear_req  in  1  single-cycle pulse that starts a full-screen clear
- clear_busy  out  1  sweep in progress
- clear_done  out  1  one-cycle pulse when the sweep finishes
- oob  out  1  one-cycle pulse when an accepted pixel was out of range
- plot  out  1  adapter write enable
- x  out  8  adapter x
- y  out  7  adapter y
- colour  out  3  adapter colour

## Operation
- Reset values:
  - plot=0, x=0, y=0, colour=0
  - snake_ready=0, food_ready=0
  - clear_busy=0, clear_done=0, oob=0
  - state=S_SERVE, rr_last=SNAKE, so food wins the first tie
- State S_SERVE:
  - Only one valid is high: that requester gets ready=1 in the same cycle. This is combinational from valid and state.
  - Both valids are high: round-robin arbitration. The grant goes to the requester not in rr_last, and rr_last is updated.
  - A transfer occurs when valid && ready. Exactly one transfer can occur per cycle.
  - If clear_req=1 in the same cycle: no ready is asserted, and the next state is S_CLEAR. Clear takes priority over both requesters.
- State S_CLEAR:
  - Both readies are held at 0 and clear_busy=1.
  - An internal counter sweeps y-major: x runs 0..SCR_W-1 within each row, and rows run y=0..SCR_H-1.
  - Each cycle writes plot=1 with colour=BG_COLOUR. A full sweep takes 19200 cycles.
  - After the pixel (159,119) is issued, the block moves to S_DONE.
  - clear_req is ignored while in this state.
- State S_DONE: lasts one cycle. clear_done=1 and clear_busy=0, no requester is granted, then the block returns to S_SERVE.
- Range check:
  - An accepted pixel with x>=SCR_W or y>=SCR_H is still consumed (ready=1).
  - For that pixel, plot stays 0 and oob pulses on the following cycle. x, y and colour still register the value.
- Idle: no transfer and no sweep means plot=0 next cycle. x, y and colour hold their last values.
- Reset mid-sweep aborts the sweep immediately. No clear_done is issued.

## Timing
- Output latency: a transfer accepted in cycle N puts plot, x, y and colour at the adapter in cycle N+1.
- Sweep latency: clear_req in cycle N causes clear_busy=1 and the pixel (0,0) plot in N+1. The last pixel is plotted in N+19200. clear_done=1 in N+19201, and S_SERVE grants resume in N+19202.
- Throughput: sustained one pixel per cycle. With both requesters continuously valid, grants strictly alternate.
- Requesters must hold their valid and data stable until ready. Dropping valid before ready is legal, and that pixel is never plotted.

## Configuration
- Macro VGA_PLOT_CLEAR_EN.
- Defined: the clear sweep, S_CLEAR and S_DONE are present as described above.
- Undefined:
  - clear_req is ignored.
  - clear_busy and clear_done are tied 0.
  - The FSM reduces to S_SERVE only and no sweep counter is synthesised.
  - Behaviour is otherwise identical.

## Structure
- Shared package snake_pkg holds:
  - SCR_W and SCR_H defaults
  - colour_t (3-bit)
  - colour constants: BLACK=3'b000, RED=3'b100, WHITE=3'b111
  - the state enum S_SERVE, S_CLEAR, S_DONE
- One sub-module, screen_sweep_counter:
  - x/y raster counter with enable, start and last flag
  - instantiated only under VGA_PLOT_CLEAR_EN

## Test plan
- Reset, then snake_valid=1 with (80,60,3'b111) for 1 cycle -> snake_ready=1 in the same cycle; next cycle plot=1, x=80, y=60, colour=3'b111.
- Both valid continuously, food (10,10,3'b100) and snake (20,20,3'b000), for 4 cycles -> grant order food, snake, food, snake; plot stays high for 4 consecutive cycles.
- food_valid=1 with x=160, y=5 -> food_ready=1; next cycle plot=0 and oob=1.
- clear_req pulse with snake_valid held high -> snake_ready=0 for 19201 cycles; exactly 19200 plots with colour=0, the last at (159,119); then clear_done for 1 cycle; snake granted the following cycle.
- Reset asserted at pixel 5000 of a sweep -> next cycle all outputs at their reset values; clear_done never pulses.
- Build without VGA_PLOT_CLEAR_EN, pulse clear_req -> clear_busy stays 0 and requesters are served with no interruption.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared screen geometry, colour and arbiter state types for the snake game datapath.
package snake_pkg;

  localparam int unsigned DEF_SCR_W = 160;
  localparam int unsigned DEF_SCR_H = 120;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned COLOUR_W  = 3;

  typedef logic [COLOUR_W-1:0] colour_t;

  localparam colour_t BLACK = 3'b000;
  localparam colour_t RED   = 3'b100;
  localparam colour_t WHITE = 3'b111;

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } plot_state_e;

  typedef enum logic {
    REQ_SNAKE = 1'b0,
    REQ_FOOD  = 1'b1
  } req_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    colour_t        colour;
  } pixel_t;

endpackage

// File: rtl/screen_sweep_counter.sv
// Raster x/y counter for the full-screen clear; x runs fastest, wraps to origin after the last pixel.
// Only built when VGA_PLOT_CLEAR_EN is defined.
`ifdef VGA_PLOT_CLEAR_EN
module screen_sweep_counter
  import snake_pkg::*;
#(
  parameter int unsigned SCR_W = DEF_SCR_W,
  parameter int unsigned SCR_H = DEF_SCR_H
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic           en_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCR_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCR_H - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           row_end;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    row_end = (x_q == X_MAX);
    if (start_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (row_end) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = row_end && (y_q == Y_MAX);

endmodule
`endif

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the VGA adapter write port between snake and food requesters,
// with an optional full-screen clear sweep enabled by VGA_PLOT_CLEAR_EN.
module vga_plot_arbiter
  import snake_pkg::*;
#(
  parameter int unsigned SCR_W     = DEF_SCR_W,
  parameter int unsigned SCR_H     = DEF_SCR_H,
  parameter colour_t     BG_COLOUR = BLACK
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           snake_valid,
  input  logic [X_W-1:0] snake_x,
  input  logic [Y_W-1:0] snake_y,
  input  colour_t        snake_colour,
  output logic           snake_ready,
  input  logic           food_valid,
  input  logic [X_W-1:0] food_x,
  input  logic [Y_W-1:0] food_y,
  input  colour_t        food_colour,
  output logic           food_ready,
  input  logic           clear_req,
  output logic           clear_busy,
  output logic           clear_done,
  output logic           oob,
  output logic           plot,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output colour_t        colour
);

  req_e           rr_last_q, rr_last_d;
  logic           serve;
  logic           sweep_issue;
  logic [X_W-1:0] sw_x;
  logic [Y_W-1:0] sw_y;

  pixel_t         sel_px;
  logic           in_range;
  logic           plot_q, plot_d;
  logic           oob_q, oob_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  colour_t        colour_q, colour_d;

`ifdef VGA_PLOT_CLEAR_EN
  plot_state_e state_q, state_d;
  logic        sweep_end_q, sweep_end_d;
  logic        sw_start, sw_last;
  logic        clear_busy_q, clear_busy_d;
  logic        clear_done_q, clear_done_d;

  screen_sweep_counter #(
    .SCR_W (SCR_W),
    .SCR_H (SCR_H)
  ) u_sweep (
    .clk     (clk),
    .reset   (reset),
    .start_i (sw_start),
    .en_i    (sweep_issue),
    .x_o     (sw_x),
    .y_o     (sw_y),
    .last_o  (sw_last)
  );

  // The first sweep pixel is issued in the clear_req cycle so it reaches the adapter one cycle later.
  always_comb begin
    state_d      = state_q;
    sweep_issue  = 1'b0;
    sw_start     = 1'b0;
    serve        = 1'b0;
    case (state_q)
      S_SERVE: begin
        if (clear_req) begin
          state_d     = S_CLEAR;
          sweep_issue = 1'b1;
        end else begin
          serve = 1'b1;
        end
      end
      S_CLEAR: begin
        if (sweep_end_q) state_d = S_DONE;
        else             sweep_issue = 1'b1;
      end
      S_DONE: begin
        state_d  = S_SERVE;
        sw_start = 1'b1;
      end
      default: state_d = S_SERVE;
    endcase
    sweep_end_d  = sweep_issue && sw_last;
    clear_busy_d = (state_d == S_CLEAR);
    clear_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SERVE;
      sweep_end_q  <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_end_q  <= sweep_end_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign serve            = 1'b1;
  assign sweep_issue      = 1'b0;
  assign sw_x             = '0;
  assign sw_y             = '0;
  assign clear_busy       = 1'b0;
  assign clear_done       = 1'b0;
`endif

  // Single requester is granted directly; on contention the one not served last wins.
  always_comb begin
    snake_ready = 1'b0;
    food_ready  = 1'b0;
    rr_last_d   = rr_last_q;
    if (serve) begin
      if (snake_valid && food_valid) begin
        if (rr_last_q == REQ_SNAKE) begin
          food_ready = 1'b1;
          rr_last_d  = REQ_FOOD;
        end else begin
          snake_ready = 1'b1;
          rr_last_d   = REQ_SNAKE;
        end
      end else begin
        snake_ready = snake_valid;
        food_ready  = food_valid;
      end
    end
  end

  always_comb begin
    sel_px   = food_ready ? pixel_t'{food_x, food_y, food_colour}
                          : pixel_t'{snake_x, snake_y, snake_colour};
    in_range = (32'(sel_px.x) < SCR_W) && (32'(sel_px.y) < SCR_H);
    plot_d   = 1'b0;
    oob_d    = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (sweep_issue) begin
      plot_d   = 1'b1;
      x_d      = sw_x;
      y_d      = sw_y;
      colour_d = BG_COLOUR;
    end else if (snake_ready || food_ready) begin
      // Out-of-range pixels are consumed and registered but never written.
      plot_d   = in_range;
      oob_d    = !in_range;
      x_d      = sel_px.x;
      y_d      = sel_px.y;
      colour_d = sel_px.colour;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= REQ_SNAKE;
      plot_q    <= 1'b0;
      oob_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      plot_q    <= plot_d;
      oob_q     <= oob_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
    end
  end

  assign plot   = plot_q;
  assign oob    = oob_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed vector table, clear-sweep sequences and a randomized
// run checked against an arbitration/range model.
module tb_vga_plot_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       snake_valid, food_valid, clear_req;
  logic [7:0] snake_x, food_x;
  logic [6:0] snake_y, food_y;
  logic [2:0] snake_colour, food_colour;
  logic       snake_ready, food_ready, clear_busy, clear_done, oob, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

`ifdef VGA_PLOT_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  vga_plot_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .snake_valid  (snake_valid),
    .snake_x      (snake_x),
    .snake_y      (snake_y),
    .snake_colour (snake_colour),
    .snake_ready  (snake_ready),
    .food_valid   (food_valid),
    .food_x       (food_x),
    .food_y       (food_y),
    .food_colour  (food_colour),
    .food_ready   (food_ready),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oob          (oob),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    logic       fv;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [2:0] fc;
    logic       cr;
    logic       e_sr, e_fr, e_plot, e_oob;
  } vec_t;

  // Model state: who wins the next tie, and the last pixel the adapter registers hold.
  bit         tie_food;
  logic [7:0] ex_x;
  logic [6:0] ex_y;
  logic [2:0] ex_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic sv, input logic [7:0] sx, input logic [6:0] sy,
                              input logic [2:0] sc, input logic fv, input logic [7:0] fx,
                              input logic [6:0] fy, input logic [2:0] fc, input logic cr,
                              input logic e_sr, input logic e_fr, input logic e_plot,
                              input logic e_oob);
    vec_t v;
    v.sv = sv; v.sx = sx; v.sy = sy; v.sc = sc;
    v.fv = fv; v.fx = fx; v.fy = fy; v.fc = fc; v.cr = cr;
    v.e_sr = e_sr; v.e_fr = e_fr; v.e_plot = e_plot; v.e_oob = e_oob;
    return v;
  endfunction

  task automatic drive_idle();
    snake_valid = 0; snake_x = 0; snake_y = 0; snake_colour = 0;
    food_valid = 0; food_x = 0; food_y = 0; food_colour = 0; clear_req = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    tie_food = 1'b1;
    ex_x = 0; ex_y = 0; ex_c = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"}, plot, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_colour"}, colour, 0);
    check({tag, "_oob"}, oob, 0);
    check({tag, "_busy"}, clear_busy, 0);
    check({tag, "_done"}, clear_done, 0);
  endtask

  // Drive one cycle of stimulus, check readies mid-cycle and registered outputs after the edge.
  task automatic apply(input vec_t v);
    snake_valid = v.sv; snake_x = v.sx; snake_y = v.sy; snake_colour = v.sc;
    food_valid = v.fv; food_x = v.fx; food_y = v.fy; food_colour = v.fc;
    clear_req = v.cr;
    @(negedge clk);
    check("snake_ready", snake_ready, v.e_sr);
    check("food_ready", food_ready, v.e_fr);
    if (v.e_fr) begin
      ex_x = v.fx; ex_y = v.fy; ex_c = v.fc;
    end else if (v.e_sr) begin
      ex_x = v.sx; ex_y = v.sy; ex_c = v.sc;
    end
    @(posedge clk);
    #1;
    check("plot", plot, v.e_plot);
    check("oob", oob, v.e_oob);
    check("x", x, ex_x);
    check("y", y, ex_y);
    check("colour", colour, ex_c);
    check("clear_busy", clear_busy, 0);
    check("clear_done", clear_done, 0);
  endtask

  // Arbitration and range rules applied to a stimulus vector (no clear in effect).
  task automatic predict(inout vec_t v);
    int px, py;
    v.e_sr = 0; v.e_fr = 0; v.e_plot = 0; v.e_oob = 0;
    if (v.sv && v.fv) begin
      if (tie_food) v.e_fr = 1; else v.e_sr = 1;
      tie_food = !tie_food;
    end else begin
      v.e_sr = v.sv;
      v.e_fr = v.fv;
    end
    if (v.e_sr || v.e_fr) begin
      px = v.e_fr ? int'(v.fx) : int'(v.sx);
      py = v.e_fr ? int'(v.fy) : int'(v.sy);
      v.e_plot = (px < 160) && (py < 120);
      v.e_oob  = !v.e_plot;
    end
  endtask

`ifdef VGA_PLOT_CLEAR_EN
  task automatic sweep_full();
    int zero_rdy = 0, nplot = 0, nbad = 0;
    logic [7:0] lx = 0;
    logic [6:0] ly = 0;
    drive_idle();
    snake_valid = 1; snake_x = 1; snake_y = 2; snake_colour = 7; clear_req = 1;
    @(negedge clk);
    check("clear_blocks_snake", snake_ready, 0);
    @(posedge clk);
    #1;
    clear_req = 0;
    for (int i = 0; i < 19200; i++) begin
      if (plot === 1'b1) nplot++;
      if (plot !== 1'b1 || colour !== 3'b000 || x !== 8'(i % 160) || y !== 7'(i / 160) ||
          clear_busy !== 1'b1 || clear_done !== 1'b0 || oob !== 1'b0)
        nbad++;
      lx = x; ly = y;
      @(negedge clk);
      if (snake_ready === 1'b0) zero_rdy++;
      @(posedge clk);
      #1;
    end
    check("sweep_plot_count", nplot, 19200);
    check("sweep_bad_cycles", nbad, 0);
    check("sweep_last_x", lx, 159);
    check("sweep_last_y", ly, 119);
    check("sweep_done_pulse", clear_done, 1);
    check("sweep_done_busy", clear_busy, 0);
    check("sweep_done_plot", plot, 0);
    @(negedge clk);
    if (snake_ready === 1'b0) zero_rdy++;
    check("sweep_ready_low_cycles", zero_rdy, 19201);
    @(posedge clk);
    #1;
    check("after_done_cleared", clear_done, 0);
    @(negedge clk);
    check("snake_resumes", snake_ready, 1);
    @(posedge clk);
    #1;
    check("resume_plot", plot, 1);
    check("resume_x", x, 1);
    check("resume_y", y, 2);
    check("resume_colour", colour, 7);
    drive_idle();
  endtask

  task automatic sweep_abort();
    int stray = 0;
    drive_idle();
    clear_req = 1;
    @(posedge clk);
    #1;
    clear_req = 0;
    repeat (5000) @(posedge clk);
    #1;
    check("abort_at_x", x, 40);
    check("abort_at_y", y, 31);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("abort");
    for (int i = 0; i < 19400; i++) begin
      @(posedge clk);
      #1;
      if (clear_done !== 1'b0 || clear_busy !== 1'b0 || plot !== 1'b0) stray++;
    end
    check("abort_no_done", stray, 0);
  endtask
`endif

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Directed vectors, valid from a fresh reset (food wins the first tie).
    tbl.push_back(mk(1, 80, 60, 3'b111, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20, 20, 3'b000, 1, 10, 10, 3'b100, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 20, 20, 3'b000, 1, 10, 10, 3'b100, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 20, 20, 3'b000, 1, 10, 10, 3'b100, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 20, 20, 3'b000, 1, 10, 10, 3'b100, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 160, 5, 3'b010, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 3, 120, 3'b001, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 159, 119, 3'b101, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3'b011, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (!CLEAR_EN) begin
      tbl.push_back(mk(1, 7, 8, 3'b110, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 9, 9, 3'b001, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    do_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    check("reset_snake_ready", snake_ready, 0);
    check("reset_food_ready", food_ready, 0);
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);

`ifdef VGA_PLOT_CLEAR_EN
    sweep_full();
    sweep_abort();
`endif

    do_reset();
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if (!(v.sv && !v.e_sr && $urandom_range(3) != 0)) begin
        v.sv = 1'($urandom_range(1));
        v.sx = 8'($urandom_range(170));
        v.sy = 7'($urandom_range(127));
        v.sc = 3'($urandom);
      end
      if (!(v.fv && !v.e_fr && $urandom_range(3) != 0)) begin
        v.fv = 1'($urandom_range(1));
        v.fx = 8'($urandom_range(170));
        v.fy = 7'($urandom_range(127));
        v.fc = 3'($urandom);
      end
      v.cr = CLEAR_EN ? 1'b0 : 1'($urandom_range(9) == 0);
      predict(v);
      apply(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
